// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory request/response channel, decode-side
// instruction handoff, and the branch redirect from the resolve stage.
interface fetch_if;
  // Handshakes: a request transfers on a rising edge where imem_req and
  // imem_ready are both high; a response transfers on any edge with imem_valid
  // high; an instruction transfers to decode on an edge with if_valid and
  // if_ready both high. Payloads are stable while their valid is held.
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic        imem_valid;
  logic [15:0] imem_rdata;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus_two;
  logic        if_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus_two, halt,
    input  imem_ready, imem_valid, imem_rdata, if_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus_two, halt,
    output imem_ready, imem_valid, imem_rdata, if_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one memory request at a
// time, buffers one instruction for decode, and applies branch redirects.
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input  logic       clk,
  input  logic       rst_n,
  fetch_if.master    bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] pc, pc_nxt;
  logic [15:0] buffer, buffer_nxt;
  logic        squash, squash_nxt;
  logic [15:0] target;

  assign target = {bus.redirect_pc[15:1], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_REQ;
      pc     <= RESET_PC;
      buffer <= 16'h0000;
      squash <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      buffer <= buffer_nxt;
      squash <= squash_nxt;
    end
  end

  // Redirect wins in every state; a redirect while a fetch is in flight marks
  // that response for squashing unless it is arriving on the same edge.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    buffer_nxt = buffer;
    squash_nxt = squash;
    case (state)
      ST_REQ: begin
        if (bus.redirect) begin
          pc_nxt = target;
        end else if (bus.imem_ready) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.redirect) begin
          pc_nxt = target;
          if (bus.imem_valid) begin
            squash_nxt = 1'b0;
            state_nxt  = ST_REQ;
          end else begin
            squash_nxt = 1'b1;
          end
        end else if (bus.imem_valid) begin
          if (squash) begin
            squash_nxt = 1'b0;
            state_nxt  = ST_REQ;
          end else begin
            buffer_nxt = bus.imem_rdata;
            state_nxt  = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (bus.redirect) begin
          pc_nxt    = target;
          state_nxt = ST_REQ;
        end else if (bus.if_ready) begin
          if (buffer[15:12] == HLT_OPCODE) begin
            state_nxt = ST_HALT;
          end else begin
            pc_nxt    = pc + 16'd2;
            state_nxt = ST_REQ;
          end
        end
      end
      ST_HALT: begin
        if (bus.redirect) begin
          pc_nxt    = target;
          state_nxt = ST_REQ;
        end
      end
      default: state_nxt = ST_REQ;
    endcase
  end

  assign bus.imem_req       = (state == ST_REQ) & ~bus.redirect & rst_n;
  assign bus.imem_addr      = pc;
  assign bus.if_valid       = (state == ST_HOLD);
  assign bus.if_instr       = buffer;
  assign bus.if_pc          = pc;
  assign bus.if_pc_plus_two = pc + 16'd2;
  assign bus.halt           = (state == ST_HALT);
  assign dbg_state          = state;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with literal expectations, then
// random memory/decode/redirect traffic checked every cycle against a model.
module tb_fetch_ctrl;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  fetch_if    bus();

  fetch_ctrl #(.RESET_PC(RESET_PC), .HLT_OPCODE(4'hF)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.master),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] mem [0:32767];
  int          lat_cfg = 1;   // 0 selects a random latency per request

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Flags describe what the front end is doing, not how the DUT encodes it.
  logic [15:0] m_pc, m_buf;
  logic        m_busy, m_squash, m_full, m_halted;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= RESET_PC; m_buf <= 16'h0; m_busy <= 1'b0;
      m_squash <= 1'b0; m_full <= 1'b0; m_halted <= 1'b0;
    end else if (bus.redirect) begin
      m_pc <= {bus.redirect_pc[15:1], 1'b0};
      m_full <= 1'b0;
      m_halted <= 1'b0;
      if (m_busy && bus.imem_valid) begin
        m_busy <= 1'b0; m_squash <= 1'b0;
      end else if (m_busy) begin
        m_squash <= 1'b1;
      end
    end else if (!m_halted) begin
      if (m_full) begin
        if (bus.if_ready) begin
          m_full <= 1'b0;
          if (m_buf[15:12] == 4'hF) m_halted <= 1'b1;
          else m_pc <= m_pc + 16'd2;
        end
      end else if (m_busy) begin
        if (bus.imem_valid) begin
          m_busy <= 1'b0;
          if (m_squash) m_squash <= 1'b0;
          else begin m_full <= 1'b1; m_buf <= bus.imem_rdata; end
        end
      end else if (bus.imem_ready) begin
        m_busy <= 1'b1;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("imem_req", 16'(bus.imem_req), 16'(!m_busy && !m_full && !m_halted && !bus.redirect));
      chk("imem_addr", bus.imem_addr, m_pc);
      chk("if_valid", 16'(bus.if_valid), 16'(m_full));
      if (m_full) chk("if_instr", bus.if_instr, m_buf);
      chk("if_pc", bus.if_pc, m_pc);
      chk("if_pc_plus_two", bus.if_pc_plus_two, m_pc + 16'd2);
      chk("halt", 16'(bus.halt), 16'(m_halted));
    end
  end

  // ---------------- memory responder ----------------
  task automatic mem_responder();
    logic        acc, pend;
    logic [15:0] acc_addr, pend_addr;
    int          wl;
    pend = 1'b0; wl = 0; pend_addr = 16'h0;
    forever begin
      @(negedge clk);
      acc      = bus.imem_req && bus.imem_ready;
      acc_addr = bus.imem_addr;
      @(posedge clk);
      #1;
      if (bus.imem_valid) pend = 1'b0;
      if (acc) begin
        pend      = 1'b1;
        pend_addr = acc_addr;
        wl        = (lat_cfg == 0) ? $urandom_range(0, 2) : lat_cfg - 1;
      end else if (pend && wl > 0) begin
        wl--;
      end
      bus.imem_valid = pend && (wl == 0);
      bus.imem_rdata = bus.imem_valid ? mem[pend_addr[15:1]] : 16'($urandom);
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // sel: 0 = if_valid, 1 = halt, 2 = imem_req
  task automatic wait_for(input string name, input int sel, input int bound, output int n);
    logic hit;
    hit = 1'b0;
    n = 0;
    while (!hit && n < bound) begin
      @(negedge clk);
      n++;
      hit = (sel == 0) ? bus.if_valid : (sel == 1) ? bus.halt : bus.imem_req;
    end
    chk({name, "_reached"}, 16'(hit), 16'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    for (int i = 0; i < 32768; i++) begin
      mem[i] = 16'($urandom);
      if (mem[i][15:12] == 4'hF) mem[i][15:12] = 4'h7;
    end
    mem[16'h0000 >> 1] = 16'h0123;
    mem[16'h0002 >> 1] = 16'h1456;
    mem[16'h0004 >> 1] = 16'h2222;
    mem[16'h0006 >> 1] = 16'hBEEF;
    mem[16'h0040 >> 1] = 16'h3333;
    mem[16'h0042 >> 1] = 16'hF000;
    mem[16'h0010 >> 1] = 16'h4444;
    mem[16'hFFFE >> 1] = 16'h1234;

    rst_n = 1'b0;
    bus.imem_ready = 1'b1; bus.imem_valid = 1'b0; bus.imem_rdata = 16'h0;
    bus.if_ready = 1'b1; bus.redirect = 1'b0; bus.redirect_pc = 16'h0;
    fork mem_responder(); join_none

    // reset state
    #2;
    chk("rst_imem_req", 16'(bus.imem_req), 16'd0);
    chk("rst_imem_addr", bus.imem_addr, RESET_PC);
    chk("rst_if_valid", 16'(bus.if_valid), 16'd0);
    chk("rst_if_instr", bus.if_instr, 16'h0000);
    chk("rst_if_pc", bus.if_pc, RESET_PC);
    chk("rst_halt", 16'(bus.halt), 16'd0);

    // sequential fetch with a 1-cycle memory
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("seq_first_req", 16'(bus.imem_req), 16'd1);
    chk("seq_first_addr", bus.imem_addr, 16'h0000);
    wait_for("seq_v0", 0, 10, n);
    chk("seq_v0_cycles", 16'(n), 16'd2);
    chk("seq_v0_instr", bus.if_instr, 16'h0123);
    chk("seq_v0_pc", bus.if_pc, 16'h0000);
    chk("seq_v0_pc2", bus.if_pc_plus_two, 16'h0002);
    wait_for("seq_v1", 0, 10, n);
    chk("seq_v1_cycles", 16'(n), 16'd3);
    chk("seq_v1_instr", bus.if_instr, 16'h1456);
    chk("seq_v1_pc", bus.if_pc, 16'h0002);

    // memory backpressure in REQ
    tick();
    bus.imem_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("bp_req", 16'(bus.imem_req), 16'd1);
      chk("bp_addr", bus.imem_addr, 16'h0004);
    end
    tick();
    bus.imem_ready = 1'b1; lat_cfg = 2; bus.if_ready = 1'b0;
    wait_for("bp_v", 0, 10, n);
    chk("bp_v_cycles", 16'(n), 16'd4);
    chk("bp_v_instr", bus.if_instr, 16'h2222);

    // decode stall in HOLD
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_valid", 16'(bus.if_valid), 16'd1);
      chk("stall_instr", bus.if_instr, 16'h2222);
      chk("stall_pc", bus.if_pc, 16'h0004);
      chk("stall_req", 16'(bus.imem_req), 16'd0);
    end
    tick();
    bus.if_ready = 1'b1; lat_cfg = 3;
    @(negedge clk);
    chk("stall_accept_pc", bus.if_pc, 16'h0004);
    @(negedge clk);
    chk("stall_next_addr", bus.imem_addr, 16'h0006);
    chk("stall_next_req", 16'(bus.imem_req), 16'd1);

    // redirect while the 0x0006 fetch (0xBEEF) is in flight
    tick();
    bus.redirect = 1'b1; bus.redirect_pc = 16'h0041;
    tick();
    bus.redirect = 1'b0;
    wait_for("rdw_req", 2, 10, n);
    chk("rdw_req_cycles", 16'(n), 16'd3);
    chk("rdw_addr", bus.imem_addr, 16'h0040);
    wait_for("rdw_v", 0, 10, n);
    chk("rdw_instr", bus.if_instr, 16'h3333);
    chk("rdw_pc", bus.if_pc, 16'h0040);
    tick();
    lat_cfg = 1;

    // HLT at 0x0042
    wait_for("hlt", 1, 20, n);
    repeat (10) begin
      @(negedge clk);
      chk("hlt_halt", 16'(bus.halt), 16'd1);
      chk("hlt_req", 16'(bus.imem_req), 16'd0);
      chk("hlt_pc", bus.imem_addr, 16'h0042);
      chk("hlt_valid", 16'(bus.if_valid), 16'd0);
    end
    tick();
    bus.redirect = 1'b1; bus.redirect_pc = 16'h0010;
    @(negedge clk);
    chk("hlt_rd_halt", 16'(bus.halt), 16'd1);
    tick();
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("hlt_exit_halt", 16'(bus.halt), 16'd0);
    chk("hlt_exit_addr", bus.imem_addr, 16'h0010);
    chk("hlt_exit_req", 16'(bus.imem_req), 16'd1);

    // PC wrap at 0xFFFE (redirect lands while the 0x0010 response returns)
    tick();
    bus.redirect = 1'b1; bus.redirect_pc = 16'hFFFE;
    tick();
    bus.redirect = 1'b0;
    wait_for("wrap_v", 0, 10, n);
    chk("wrap_instr", bus.if_instr, 16'h1234);
    chk("wrap_pc", bus.if_pc, 16'hFFFE);
    chk("wrap_pc2", bus.if_pc_plus_two, 16'h0000);
    wait_for("wrap_req", 2, 10, n);
    chk("wrap_addr", bus.imem_addr, 16'h0000);
    wait_for("wrap_v2", 0, 10, n);
    chk("wrap_v2_instr", bus.if_instr, 16'h0123);
    tick();
    lat_cfg = 3;
    wait_for("ar_req", 2, 10, n);
    chk("ar_addr", bus.imem_addr, 16'h0002);

    // async reset mid-WAIT; the late response must be ignored
    @(posedge clk);
    #3 rst_n = 1'b0;
    bus.imem_ready = 1'b0;
    #1;
    chk("ar_req_low", 16'(bus.imem_req), 16'd0);
    chk("ar_addr_reset", bus.imem_addr, RESET_PC);
    chk("ar_pc_reset", bus.if_pc, RESET_PC);
    chk("ar_valid", 16'(bus.if_valid), 16'd0);
    chk("ar_halt", 16'(bus.halt), 16'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("ar_late_valid", 16'(bus.if_valid), 16'd0);
      chk("ar_late_req", 16'(bus.imem_req), 16'd1);
      chk("ar_late_addr", bus.imem_addr, RESET_PC);
    end

    // random traffic
    lat_cfg = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      bus.imem_ready  = ($urandom_range(0, 3) != 0);
      bus.if_ready    = ($urandom_range(0, 9) < 7);
      bus.redirect    = ($urandom_range(0, 99) < 8);
      bus.redirect_pc = 16'($urandom);
      if ($urandom_range(0, 49) == 0) mem[$urandom_range(0, 32767)][15:12] = 4'hF;
    end
    tick();
    bus.redirect = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
